// File: rtl/execute_md.sv
// Execute stage with operand forwarding and an iterative radix-2 mul/div unit.
// Latency: non-md ops 1 cycle; mul/div XLEN+1 cycles (33 for word forms) when unstalled.
// Backpressure: stall_in holds the output register and the DONE result; md_busy_out stalls upstream while a mul/div is in flight.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   stall_in, flush_in              downstream stall, kill current instruction
//   valid_in, md_in, md_op_in,      instruction qualifiers (md_op: MUL, MULH, MULHSU, MULHU,
//   word_in                         DIV, DIVU, REM, REMU; word_in selects the RV64 *W form)
//   rs1/rs2/rd_in, rd_write_in      register specifiers
//   rs1/rs2_value_in, alu_result_in register-file operands and external ALU result
//   wb_rd_in/_write_in/_value_in    writeback forwarding source
//   rs1/rs2_fwd_out                 forwarded operands (to the external ALU)
//   md_busy_out                     upstream stall request
//   valid_out, rd_write_out, rd_out, result_out, rs2_value_out   registered stage outputs
module execute_md #(
  parameter int XLEN      = 64,
  parameter int REG_BITS  = 9,
  parameter int MD_ENABLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_in,
  input  logic                flush_in,
  input  logic                valid_in,
  input  logic                md_in,
  input  logic [2:0]          md_op_in,
  input  logic                word_in,
  input  logic [REG_BITS-1:0] rs1_in,
  input  logic [REG_BITS-1:0] rs2_in,
  input  logic [REG_BITS-1:0] rd_in,
  input  logic                rd_write_in,
  input  logic [XLEN-1:0]     rs1_value_in,
  input  logic [XLEN-1:0]     rs2_value_in,
  input  logic [XLEN-1:0]     alu_result_in,
  input  logic [REG_BITS-1:0] wb_rd_in,
  input  logic                wb_rd_write_in,
  input  logic [XLEN-1:0]     wb_rd_value_in,
  output logic [XLEN-1:0]     rs1_fwd_out,
  output logic [XLEN-1:0]     rs2_fwd_out,
  output logic                md_busy_out,
  output logic                valid_out,
  output logic                rd_write_out,
  output logic [REG_BITS-1:0] rd_out,
  output logic [XLEN-1:0]     result_out,
  output logic [XLEN-1:0]     rs2_value_out
);

  localparam int CW = $clog2(XLEN + 1);
  // Word forms live in the low 32 bits; SH moves them to the top and back.
  localparam int SH = XLEN - 32;

  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sgn);
    logic [XLEN-1:0] t;
    t = x << SH;
    if (sgn) return $unsigned($signed(t) >>> SH);
    return t >> SH;
  endfunction

  // Own output register wins over writeback; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd(
    input logic [REG_BITS-1:0] rs,
    input logic [XLEN-1:0]     rf_val,
    input logic                own_wr,
    input logic [REG_BITS-1:0] own_rd,
    input logic [XLEN-1:0]     own_val,
    input logic                wb_wr,
    input logic [REG_BITS-1:0] wb_rd,
    input logic [XLEN-1:0]     wb_val
  );
    if (rs != '0 && own_wr && own_rd == rs) return own_val;
    if (rs != '0 && wb_wr && wb_rd == rs)   return wb_val;
    return rf_val;
  endfunction

  logic                valid_q, valid_d;
  logic                rd_write_q, rd_write_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [XLEN-1:0]     rs2_q, rs2_d;

  logic                md_busy;
  logic [XLEN-1:0]     md_result;
  logic                md_sel;

  always_comb begin
    rs1_fwd_out = fwd(rs1_in, rs1_value_in, rd_write_q, rd_q, result_q,
                      wb_rd_write_in, wb_rd_in, wb_rd_value_in);
    rs2_fwd_out = fwd(rs2_in, rs2_value_in, rd_write_q, rd_q, result_q,
                      wb_rd_write_in, wb_rd_in, wb_rd_value_in);
  end

  assign md_sel      = (MD_ENABLE != 0) && md_in;
  assign md_busy_out = md_busy;

  if (MD_ENABLE != 0) begin : g_md
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // acc: multiply high half / divide partial remainder
    // lo:  multiplier being consumed / dividend shifting out, quotient shifting in
    logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d, sa_q, sa_d, neg_q, neg_d;

    logic              word_eff, a_signed, b_signed, a_neg, b_neg, div_ge;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, quo, rem, res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_raw, prod;

    assign md_busy = valid_in && md_in && (state_q != DONE);

    always_comb begin
      // Issue-side operand preparation: signs are stripped here and restored at DONE.
      word_eff = (XLEN == 64) && word_in;
      a_signed = md_op_in[2] ? ~md_op_in[0] : (md_op_in[1:0] != 2'd3);
      b_signed = md_op_in[2] ? ~md_op_in[0] : ~md_op_in[1];
      a_ext    = word_eff ? ext32(rs1_fwd_out, a_signed) : rs1_fwd_out;
      b_ext    = word_eff ? ext32(rs2_fwd_out, b_signed) : rs2_fwd_out;
      a_neg    = a_signed & a_ext[XLEN-1];
      b_neg    = b_signed & b_ext[XLEN-1];
      a_mag    = a_neg ? -a_ext : a_ext;
      b_mag    = b_neg ? -b_ext : b_ext;

      // One iteration of either algorithm.
      mul_sum   = {1'b0, acc_q} + {1'b0, b_q & {XLEN{lo_q[0]}}};
      div_shift = {acc_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, b_q};
      div_ge    = div_shift >= {1'b0, b_q};

      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      b_d     = b_q;
      op_d    = op_q;
      word_d  = word_q;
      sa_d    = sa_q;
      neg_d   = neg_q;

      unique case (state_q)
        IDLE: begin
          if (valid_in && md_in && !flush_in) begin
            state_d = BUSY;
            cnt_d   = word_eff ? CW'(32) : CW'(XLEN);
            op_d    = md_op_in;
            word_d  = word_eff;
            sa_d    = a_neg;
            neg_d   = a_neg ^ b_neg;
            acc_d   = '0;
            b_d     = b_mag;
            // A 32-step divide must see the dividend MSB first, so left-align it.
            lo_d    = (md_op_in[2] && word_eff) ? (a_mag << SH) : a_mag;
          end
        end
        BUSY: begin
          cnt_d = cnt_q - CW'(1);
          if (op_q[2]) begin
            acc_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], div_ge};
          end else begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == CW'(1)) state_d = DONE;
        end
        DONE: begin
          if (!stall_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (flush_in) state_d = IDLE;

      // Result assembly from the held state; stays stable while stalled in DONE.
      // After 32 word steps the 64-bit product sits 32 bits higher in {acc, lo}.
      prod_raw = word_q ? ({acc_q, lo_q} >> 32) : {acc_q, lo_q};
      prod     = neg_q ? -prod_raw : prod_raw;
      // The unsigned algorithm already yields all ones for x/0; only the sign fix must be skipped.
      quo      = (b_q == '0) ? '1 : (neg_q ? -lo_q : lo_q);
      rem      = sa_q ? -acc_q : acc_q;
      unique case (op_q)
        3'd0:             res = prod[XLEN-1:0];
        3'd1, 3'd2, 3'd3: res = prod[2*XLEN-1:XLEN];
        3'd4, 3'd5:       res = quo;
        default:          res = rem;
      endcase
      md_result = word_q ? ext32(res, 1'b1) : res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        acc_q   <= '0;
        lo_q    <= '0;
        b_q     <= '0;
        op_q    <= '0;
        word_q  <= 1'b0;
        sa_q    <= 1'b0;
        neg_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        acc_q   <= acc_d;
        lo_q    <= lo_d;
        b_q     <= b_d;
        op_q    <= op_d;
        word_q  <= word_d;
        sa_q    <= sa_d;
        neg_q   <= neg_d;
      end
    end
  end else begin : g_no_md
    assign md_busy   = 1'b0;
    assign md_result = '0;
  end

  // Output register: bubbles keep the old data fields and only clear the qualifiers.
  always_comb begin
    valid_d    = valid_q;
    rd_write_d = rd_write_q;
    rd_d       = rd_q;
    result_d   = result_q;
    rs2_d      = rs2_q;
    if (!stall_in) begin
      if (flush_in || md_busy || !valid_in) begin
        valid_d    = 1'b0;
        rd_write_d = 1'b0;
      end else begin
        valid_d    = 1'b1;
        rd_write_d = rd_write_in;
        rd_d       = rd_in;
        result_d   = md_sel ? md_result : alu_result_in;
        rs2_d      = rs2_fwd_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rd_write_q <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      rs2_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_write_q <= rd_write_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      rs2_q      <= rs2_d;
    end
  end

  assign valid_out     = valid_q;
  assign rd_write_out  = rd_write_q;
  assign rd_out        = rd_q;
  assign result_out    = result_q;
  assign rs2_value_out = rs2_q;

endmodule

// File: tb/tb_execute_md.sv
module tb_execute_md;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in, flush_in, valid_in, md_in, word_in, rd_write_in, wb_rd_write_in;
  logic [2:0]  md_op_in;
  logic [8:0]  rs1_in, rs2_in, rd_in, wb_rd_in;
  logic [63:0] rs1_value_in, rs2_value_in, alu_result_in, wb_rd_value_in;
  logic [63:0] rs1_fwd_out, rs2_fwd_out, result_out, rs2_value_out;
  logic        md_busy_out, valid_out, rd_write_out;
  logic [8:0]  rd_out;

  execute_md #(.XLEN(64), .REG_BITS(9), .MD_ENABLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .md_in(md_in), .md_op_in(md_op_in), .word_in(word_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
    .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in), .alu_result_in(alu_result_in),
    .wb_rd_in(wb_rd_in), .wb_rd_write_in(wb_rd_write_in), .wb_rd_value_in(wb_rd_value_in),
    .rs1_fwd_out(rs1_fwd_out), .rs2_fwd_out(rs2_fwd_out), .md_busy_out(md_busy_out),
    .valid_out(valid_out), .rd_write_out(rd_write_out), .rd_out(rd_out),
    .result_out(result_out), .rs2_value_out(rs2_value_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_res_q[$];
  logic [63:0] exp_rs2_q[$];
  logic [8:0]  exp_rd_q[$];
  string       name_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every unstalled edge that leaves valid_out high is one result.
  initial begin : monitor
    logic        st;
    logic [63:0] e_res, e_rs2;
    logic [8:0]  e_rd;
    string       nm;
    forever begin
      @(posedge clk);
      st = stall_in;
      #1;
      if (rst_n && valid_out && !st) begin
        if (exp_res_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected output: got result %h with no expectation queued", result_out);
        end else begin
          e_res = exp_res_q.pop_front();
          e_rs2 = exp_rs2_q.pop_front();
          e_rd  = exp_rd_q.pop_front();
          nm    = name_q.pop_front();
          chk({nm, " result"}, result_out, e_res);
          chk({nm, " rd"}, 64'(rd_out), 64'(e_rd));
          chk({nm, " rd_write"}, 64'(rd_write_out), 64'd1);
          chk({nm, " rs2_value"}, rs2_value_out, e_rs2);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input bit md, input int op, input bit word, input int rs1, input int rs2,
                       input int rd, input logic [63:0] v1, input logic [63:0] v2,
                       input logic [63:0] alu);
    valid_in      = 1'b1;
    md_in         = md;
    md_op_in      = 3'(op);
    word_in       = word;
    rs1_in        = 9'(rs1);
    rs2_in        = 9'(rs2);
    rd_in         = 9'(rd);
    rd_write_in   = 1'b1;
    rs1_value_in  = v1;
    rs2_value_in  = v2;
    alu_result_in = alu;
  endtask

  task automatic expect_out(input logic [63:0] res, input int rd, input logic [63:0] v2, input string name);
    exp_res_q.push_back(res);
    exp_rd_q.push_back(9'(rd));
    exp_rs2_q.push_back(v2);
    name_q.push_back(name);
  endtask

  task automatic idle();
    valid_in    = 1'b0;
    md_in       = 1'b0;
    rd_write_in = 1'b0;
  endtask

  // Hold the instruction until it is accepted, counting the cycles md_busy_out was high.
  task automatic wait_accept(input int exp_busy, input string name);
    int n;
    n = 0;
    #1;
    while (md_busy_out && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({name, " busy cycles"}, 64'(n), 64'(exp_busy));
    @(negedge clk);
    idle();
  endtask

  task automatic send(input bit md, input int op, input bit word, input int rs1, input int rs2,
                      input int rd, input logic [63:0] v1, input logic [63:0] v2,
                      input logic [63:0] alu, input logic [63:0] res, input int exp_busy,
                      input string name);
    drive(md, op, word, rs1, rs2, rd, v1, v2, alu);
    expect_out(res, rd, v2, name);
    wait_accept(exp_busy, name);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  logic [63:0]  fa, fb;
  logic [127:0] refp;

  initial begin
    rst_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    valid_in = 1'b0; md_in = 1'b0; md_op_in = 3'd0; word_in = 1'b0;
    rs1_in = '0; rs2_in = '0; rd_in = '0; rd_write_in = 1'b0;
    rs1_value_in = '0; rs2_value_in = '0; alu_result_in = '0;
    wb_rd_in = '0; wb_rd_write_in = 1'b0; wb_rd_value_in = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset valid_out", 64'(valid_out), 64'd0);
    chk("reset rd_write_out", 64'(rd_write_out), 64'd0);
    chk("reset result_out", result_out, 64'd0);
    chk("reset md_busy_out", 64'(md_busy_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic ALU pass-through and the mul/div corner cases.
    send(1'b0, 0, 1'b0, 1, 20, 3, 64'h11, 64'h22, 64'h1234, 64'h1234, 0, "add");
    send(1'b1, 0, 1'b0, 1, 20, 4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0,
         64'hFFFF_FFFF_FFFF_FFEB, 65, "mul 7*-3");
    send(1'b1, 4, 1'b0, 1, 21, 5, MINN, ONES, 64'd0, MINN, 65, "div overflow");
    send(1'b1, 6, 1'b0, 1, 21, 5, MINN, ONES, 64'd0, 64'd0, 65, "rem overflow");
    send(1'b1, 5, 1'b0, 1, 21, 5, 64'd5, 64'd0, 64'd0, ONES, 65, "divu by zero");
    send(1'b1, 7, 1'b0, 1, 21, 5, 64'd5, 64'd0, 64'd0, 64'd5, 65, "remu by zero");
    send(1'b1, 1, 1'b0, 1, 21, 5, 64'h4000_0000_0000_0000, 64'd4, 64'd0, 64'd1, 65, "mulh");
    send(1'b1, 2, 1'b0, 1, 21, 5, ONES, 64'd2, 64'd0, ONES, 65, "mulhsu");
    send(1'b1, 3, 1'b0, 1, 21, 5, ONES, 64'd2, 64'd0, 64'd1, 65, "mulhu");

    // ALU result for x5 forwarded from the output register into MULHU.
    fa = 64'hDEAD_BEEF_1234_5678;
    fb = 64'h0000_0001_0000_0003;
    refp = {64'd0, fa} * {64'd0, fb};
    send(1'b0, 0, 1'b0, 1, 22, 5, 64'd0, 64'd9, fa, fa, 0, "alu x5");
    send(1'b1, 3, 1'b0, 5, 23, 6, 64'd0, fb, 64'd0, refp[127:64], 65, "mulhu fwd x5");

    // Writeback forwarding, then own-register priority over writeback.
    wb_rd_in = 9'd9; wb_rd_write_in = 1'b1; wb_rd_value_in = 64'd6;
    send(1'b1, 0, 1'b0, 9, 24, 7, 64'd100, 64'd7, 64'd0, 64'd42, 65, "mul wb fwd");
    send(1'b0, 0, 1'b0, 1, 24, 9, 64'd0, 64'd1, 64'd10, 64'd10, 0, "alu x9");
    send(1'b1, 0, 1'b0, 9, 24, 8, 64'd100, 64'd7, 64'd0, 64'd70, 65, "mul own fwd prio");
    wb_rd_write_in = 1'b0;

    // x0 is never forwarded from either source.
    send(1'b0, 0, 1'b0, 1, 24, 0, 64'd0, 64'd1, 64'd55, 64'd55, 0, "alu x0");
    wb_rd_in = 9'd0; wb_rd_write_in = 1'b1; wb_rd_value_in = 64'd99;
    send(1'b1, 0, 1'b0, 0, 25, 9, 64'd3, 64'd5, 64'd0, 64'd15, 65, "mul x0 no fwd");
    wb_rd_write_in = 1'b0;

    // Word forms: 32-bit operation, sign-extended result, 33-cycle busy.
    send(1'b1, 0, 1'b1, 1, 21, 5, 64'h0000_0000_4000_0000, 64'd2, 64'd0,
         64'hFFFF_FFFF_8000_0000, 33, "mulw");
    send(1'b1, 4, 1'b1, 1, 21, 5, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0,
         64'hFFFF_FFFF_FFFF_FFFD, 33, "divw -7/2");
    send(1'b1, 6, 1'b1, 1, 21, 5, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, ONES, 33, "remw -7/2");
    send(1'b1, 5, 1'b1, 1, 21, 5, 64'h1234_5678_FFFF_FFFF, 64'd2, 64'd0,
         64'h0000_0000_7FFF_FFFF, 33, "divuw");
    send(1'b1, 7, 1'b1, 1, 21, 5, 64'd7, 64'h0000_0001_0000_0000, 64'd0, 64'd7, 33, "remuw by zero");

    // Back-to-back mul then div, the div reading the mul result from result_out.
    send(1'b1, 0, 1'b0, 1, 26, 10, 64'd6, 64'd7, 64'd0, 64'd42, 65, "mul b2b");
    send(1'b1, 4, 1'b0, 10, 27, 11, 64'd999, 64'd5, 64'd0, 64'd8, 65, "div b2b fwd");

    // Stall held through DONE: result must survive and appear exactly once.
    @(negedge clk);
    stall_in = 1'b1;
    drive(1'b1, 0, 1'b0, 1, 28, 13, 64'd9, 64'd9, 64'd0);
    expect_out(64'd81, 13, 64'd9, "mul stalled");
    repeat (70) @(negedge clk);
    #1;
    chk("stall busy low in DONE", 64'(md_busy_out), 64'd0);
    chk("stall output held", 64'(valid_out), 64'd0);
    stall_in = 1'b0;
    @(negedge clk);
    idle();

    // Flush at BUSY cycle 10: aborted op leaves no trace, next ops run normally.
    drive(1'b1, 0, 1'b0, 1, 29, 12, 64'd3, 64'd4, 64'd0);
    repeat (10) @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    idle();
    #1;
    chk("flush valid_out", 64'(valid_out), 64'd0);
    chk("flush rd_write_out", 64'(rd_write_out), 64'd0);
    @(negedge clk);
    send(1'b0, 0, 1'b0, 1, 29, 14, 64'd0, 64'd2, 64'd77, 64'd77, 0, "add after flush");
    send(1'b1, 0, 1'b0, 1, 29, 16, 64'd5, 64'd6, 64'd0, 64'd30, 65, "mul after flush");

    // Reset in the middle of a DIVW.
    drive(1'b1, 4, 1'b1, 1, 30, 15, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    idle();
    #1;
    chk("midreset valid_out", 64'(valid_out), 64'd0);
    chk("midreset rd_write_out", 64'(rd_write_out), 64'd0);
    chk("midreset rd_out", 64'(rd_out), 64'd0);
    chk("midreset result_out", result_out, 64'd0);
    chk("midreset rs2_value_out", rs2_value_out, 64'd0);
    chk("midreset md_busy_out", 64'(md_busy_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("no stale result after reset", 64'(valid_out), 64'd0);
    @(negedge clk);
    send(1'b1, 4, 1'b1, 1, 30, 15, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0,
         64'hFFFF_FFFF_FFFF_FFFD, 33, "divw after reset");

    repeat (5) @(negedge clk);
    chk("scoreboard drained", 64'(exp_res_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
